// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and sticky-error controller for a first-word-fall-through FIFO
// built around a 2**ADDR_W-entry dual-pointer array. Optional macro: FIFO_CTRL_ALMOST_EN.
module fifo_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int COUNT_W = ADDR_W + 1
`ifdef FIFO_CTRL_ALMOST_EN
  ,
  parameter int AF_LEVEL = (1 << ADDR_W) - 4,
  parameter int AE_LEVEL = 4
`endif
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               WR_REQ,
  input  logic               RD_REQ,
  input  logic               ERR_CLR,
  output logic               WE,
  output logic [ADDR_W-1:0]  WR_PTR,
  output logic [ADDR_W-1:0]  RD_PTR,
  output logic               FULL,
  output logic               EMPTY,
  output logic [COUNT_W-1:0] COUNT,
  output logic               OVF,
`ifdef FIFO_CTRL_ALMOST_EN
  output logic               ALMOST_FULL,
  output logic               ALMOST_EMPTY,
`endif
  output logic               UDF
);

  localparam int                 DEPTH   = 1 << ADDR_W;
  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);
`ifdef FIFO_CTRL_ALMOST_EN
  localparam logic [COUNT_W-1:0] AF_C    = COUNT_W'(AF_LEVEL);
  localparam logic [COUNT_W-1:0] AE_C    = COUNT_W'(AE_LEVEL);
`endif

  logic               wr_ok;
  logic               rd_ok;
  logic [COUNT_W-1:0] count_nxt;

  // Accept terms gate on the registered flags, so a request never reaches the flags combinationally
  assign wr_ok = WR_REQ & ~FULL & RST_N;
  assign rd_ok = RD_REQ & ~EMPTY & RST_N;
  assign WE    = wr_ok;

  always_comb begin
    count_nxt = COUNT;
    if (wr_ok && !rd_ok)
      count_nxt = COUNT + 1'b1;
    else if (rd_ok && !wr_ok)
      count_nxt = COUNT - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      WR_PTR       <= '0;
      RD_PTR       <= '0;
      COUNT        <= '0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      OVF          <= 1'b0;
      UDF          <= 1'b0;
`ifdef FIFO_CTRL_ALMOST_EN
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
`endif
    end else begin
      if (wr_ok)
        WR_PTR <= WR_PTR + 1'b1;
      if (rd_ok)
        RD_PTR <= RD_PTR + 1'b1;
      COUNT <= count_nxt;
      FULL  <= (count_nxt == DEPTH_C);
      EMPTY <= (count_nxt == '0);
      // A new error in the same cycle as ERR_CLR keeps the flag set
      OVF   <= (WR_REQ & FULL)  | (OVF & ~ERR_CLR);
      UDF   <= (RD_REQ & EMPTY) | (UDF & ~ERR_CLR);
`ifdef FIFO_CTRL_ALMOST_EN
      ALMOST_FULL  <= (count_nxt >= AF_C);
      ALMOST_EMPTY <= (count_nxt <= AE_C);
`endif
    end
  end

endmodule
